// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FIFO of ALU results and status words, with a valid/ready output
// and saturating ERROR/OVF statistics plus a sticky overrun flag.
module alu_result_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_valid,
    input  logic [BITS-1:0]            i_data,
    input  logic [3:0]                 i_status,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [BITS-1:0]            o_data,
    output logic [3:0]                 o_status,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [7:0]                 o_err_cnt,
    output logic [7:0]                 o_ovf_cnt,
    output logic                       o_overrun
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [BITS-1:0] mem_data [DEPTH];
    logic [3:0] mem_status [DEPTH];
    logic push, pop;
    assign o_ready  = o_count != (AW+1)'(DEPTH);
    assign o_valid  = o_count != '0;
    assign push     = i_valid & o_ready;
    assign pop      = o_valid & i_ready;
    assign o_data   = mem_data[rd_ptr];
    assign o_status = mem_status[rd_ptr];
    // Storage is reset so the head reads zero after reset; i_clr leaves it alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]   <= '0;
                mem_status[i] <= '0;
            end
        end else if (push && !i_clr) begin
            mem_data[wr_ptr]   <= i_data;
            mem_status[wr_ptr] <= i_status;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_count   <= '0;
            o_err_cnt <= '0;
            o_ovf_cnt <= '0;
            o_overrun <= 1'b0;
        end else if (i_clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_count   <= '0;
            o_err_cnt <= '0;
            o_ovf_cnt <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            o_count <= o_count + (AW+1)'(push) - (AW+1)'(pop);
            if (push && i_status[0] && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            if (push && i_status[2] && o_ovf_cnt != 8'hFF) o_ovf_cnt <= o_ovf_cnt + 8'd1;
            if (i_valid && !o_ready) o_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed vectors with hand-computed expectations for alu_result_fifo.
module tb_alu_result_fifo;
    logic       clk = 1'b0;
    logic       rst, clr, valid, ready;
    logic [7:0] data;
    logic [3:0] status;
    logic       o_ready, o_valid, o_overrun;
    logic [7:0] o_data, o_err_cnt, o_ovf_cnt;
    logic [3:0] o_status;
    logic [2:0] o_count;
    int tests = 0;
    int fails = 0;

    alu_result_fifo #(.BITS(8), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(valid), .i_data(data),
        .i_status(status), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
        .o_status(o_status), .i_ready(ready), .o_count(o_count), .o_err_cnt(o_err_cnt),
        .o_ovf_cnt(o_ovf_cnt), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; valid = 1'b0; ready = 1'b0; data = '0; status = '0;
        #3;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_count", 32'(o_count), 0);
        check("rst_err", 32'(o_err_cnt), 0);
        check("rst_data", 32'(o_data), 0);
        step();
        rst = 1'b0;
        // fill with consumer stalled
        valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data = 8'(i * 8'h11);
            step();
        end
        check("full_count", 32'(o_count), 4);
        check("full_ready", 32'(o_ready), 0);
        check("full_head", 32'(o_data), 32'h11);
        // overrun while full
        data = 8'h55;
        step();
        valid = 1'b0;
        check("ovr_flag", 32'(o_overrun), 1);
        check("ovr_count", 32'(o_count), 4);
        // drain in order
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(o_data), 32'(i * 8'h11));
            step();
        end
        check("drain_count", 32'(o_count), 0);
        check("drain_valid", 32'(o_valid), 0);
        check("ovr_sticky", 32'(o_overrun), 1);
        // clear overrides push
        ready = 1'b0; valid = 1'b1; data = 8'h66;
        step();
        data = 8'h77;
        step();
        clr = 1'b1; data = 8'h88;
        step();
        clr = 1'b0; valid = 1'b0;
        check("clr_overrun", 32'(o_overrun), 0);
        check("clr_count", 32'(o_count), 0);
        // simultaneous push/pop at count 2, across pointer wrap
        valid = 1'b1;
        data = 8'h01; step();
        data = 8'h02; step();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = 8'(i + 3);
            check("sim_head", 32'(o_data), 32'(i + 1));
            step();
            check("sim_count", 32'(o_count), 2);
        end
        ready = 1'b0;
        data = 8'h0D; step();
        data = 8'h0E; step();
        check("sim_full", 32'(o_count), 4);
        ready = 1'b1; data = 8'h0F;
        step();
        valid = 1'b0;
        check("refuse_count", 32'(o_count), 3);
        check("refuse_ovr", 32'(o_overrun), 1);
        for (int i = 0; i < 3; i++) begin
            check("refuse_data", 32'(o_data), 32'(8'h0C + i));
            step();
        end
        check("refuse_empty", 32'(o_valid), 0);
        clr = 1'b1; step(); clr = 1'b0;
        // latency: no bypass into empty FIFO
        ready = 1'b0; valid = 1'b1; data = 8'hA5;
        #1;
        check("lat_before", 32'(o_valid), 0);
        step();
        valid = 1'b0;
        check("lat_valid", 32'(o_valid), 1);
        check("lat_data", 32'(o_data), 32'hA5);
        clr = 1'b1; step(); clr = 1'b0;
        // stats
        ready = 1'b1; valid = 1'b1; data = 8'h00;
        status = 4'b0001;
        repeat (3) step();
        status = 4'b0100;
        repeat (2) step();
        check("st_err3", 32'(o_err_cnt), 3);
        check("st_ovf2", 32'(o_ovf_cnt), 2);
        check("st_head_status", 32'(o_status), 32'h4);
        clr = 1'b1; step(); clr = 1'b0;
        check("st_clr", 32'(o_err_cnt), 0);
        status = 4'b0101;
        repeat (254) step();
        check("st_err254", 32'(o_err_cnt), 254);
        repeat (46) step();
        check("st_err_sat", 32'(o_err_cnt), 255);
        check("st_ovf_sat", 32'(o_ovf_cnt), 255);
        status = 4'b0010;
        repeat (10) step();
        check("st_err_hold", 32'(o_err_cnt), 255);
        check("st_ovf_hold", 32'(o_ovf_cnt), 255);
        // asynchronous reset mid-transfer
        clr = 1'b1; step(); clr = 1'b0;
        ready = 1'b0; status = 4'b0001;
        data = 8'h31; step();
        data = 8'h32; step();
        valid = 1'b0;
        check("mid_pre_count", 32'(o_count), 2);
        check("mid_pre_err", 32'(o_err_cnt), 2);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", 32'(o_valid), 0);
        check("mid_ready", 32'(o_ready), 1);
        check("mid_count", 32'(o_count), 0);
        check("mid_err", 32'(o_err_cnt), 0);
        rst = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
